// File: rtl/kv_cache_ctrl_pkg.sv
// Shared types for the key/value cache controller: bus widths in if_types_pkg,
// command and FSM encodings plus a saturating counter helper in ctrl_types_pkg.
package if_types_pkg;
   localparam int KEY_WIDTH   = 32;
   localparam int VALUE_WIDTH = 32;
endpackage

package ctrl_types_pkg;
   localparam int OP_WIDTH = 2;

   typedef enum logic [OP_WIDTH-1:0] {
      NOOP   = 2'd0,
      GET    = 2'd1,
      PUT    = 2'd2,
      DELETE = 2'd3
   } operation_e;

   typedef enum logic [1:0] {
      CTRL_ST_IDLE = 2'd0,
      CTRL_ST_SCAN = 2'd1,
      CTRL_ST_DONE = 2'd2
   } ctrl_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/kv_cache_ctrl_if.sv
// Command/response bundle between the OBI front end and kv_cache_ctrl.
interface kv_cache_ctrl_if;
   import if_types_pkg::*;
   import ctrl_types_pkg::*;

   operation_e             operation_in;
   logic [KEY_WIDTH-1:0]   key_in;
   logic [VALUE_WIDTH-1:0] value_in;
   logic                   ready_out;
   logic                   op_succ_out;
   logic [VALUE_WIDTH-1:0] value_out;

   modport master (output operation_in, key_in, value_in,
                   input  ready_out, op_succ_out, value_out);
   modport slave  (input  operation_in, key_in, value_in,
                   output ready_out, op_succ_out, value_out);
endinterface

// File: rtl/kv_cache_ctrl_store.sv
// Slot storage: valid/key/value arrays with one combinational read port and one
// write port. Only the valid bits are reset; key/value contents are don't-care when invalid.
module kv_store
   import if_types_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [IDX_WIDTH-1:0]   rd_idx,
   output logic                   rd_valid,
   output logic [KEY_WIDTH-1:0]   rd_key,
   output logic [VALUE_WIDTH-1:0] rd_value,
   input  logic                   wr_en,
   input  logic                   wr_set_valid,
   input  logic                   wr_clr_valid,
   input  logic [IDX_WIDTH-1:0]   wr_idx,
   input  logic [KEY_WIDTH-1:0]   wr_key,
   input  logic [VALUE_WIDTH-1:0] wr_value
);
   logic [NUM_ENTRIES-1:0] valid_q, valid_d;
   logic [KEY_WIDTH-1:0]   key_q   [NUM_ENTRIES];
   logic [VALUE_WIDTH-1:0] value_q [NUM_ENTRIES];

   // Next valid vector from set/clear requests
   always_comb begin
      valid_d = valid_q;
      if (wr_set_valid) begin
         valid_d[wr_idx] = 1'b1;
      end else if (wr_clr_valid) begin
         valid_d[wr_idx] = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Valid bits register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Key/value array write
   always_ff @(posedge clk) begin
      if (wr_en) begin
         key_q[wr_idx]   <= wr_key;
         value_q[wr_idx] <= wr_value;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_key   = key_q[rd_idx];
   assign rd_value = value_q[rd_idx];
endmodule

// File: rtl/kv_cache_ctrl.sv
// Sequential-scan key/value cache controller (IDLE -> SCAN -> DONE).
// Optional hit/miss statistics enabled by defining KV_CACHE_CTRL_STATS_EN.
module kv_cache_ctrl
   import if_types_pkg::*;
   import ctrl_types_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   kv_cache_ctrl_if.slave                    bus,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]  count_out,
   output logic [15:0]                       hit_count_out,
   output logic [15:0]                       miss_count_out
);
   localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

   ctrl_state_e            state_q, state_d;
   operation_e             op_q, op_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [VALUE_WIDTH-1:0] val_q, val_d, value_q, value_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d, hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
   logic                   hit_q, hit_d, free_found_q, free_found_d;
   logic                   succ_q, succ_d, ready_q, ready_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic                   rd_valid, match, last;
   logic [KEY_WIDTH-1:0]   rd_key;
   logic [VALUE_WIDTH-1:0] rd_value;
   logic                   wr_en, wr_set, wr_clr;
   logic [IDX_WIDTH-1:0]   wr_idx;

   kv_store #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_WIDTH(IDX_WIDTH)) u_store (
      .clk(clk), .rst_n(rst_n),
      .rd_idx(idx_q), .rd_valid(rd_valid), .rd_key(rd_key), .rd_value(rd_value),
      .wr_en(wr_en), .wr_set_valid(wr_set), .wr_clr_valid(wr_clr),
      .wr_idx(wr_idx), .wr_key(key_q), .wr_value(val_q)
   );

   assign match = rd_valid && (rd_key == key_q);
   assign last  = (idx_q == IDX_WIDTH'(NUM_ENTRIES - 1));

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CTRL_ST_IDLE;  op_q <= NOOP;  key_q <= '0;  val_q <= '0;
         idx_q <= '0;  hit_idx_q <= '0;  free_idx_q <= '0;  hit_q <= 1'b0;
         free_found_q <= 1'b0;  succ_q <= 1'b0;  value_q <= '0;  ready_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;  op_q <= op_d;  key_q <= key_d;  val_q <= val_d;
         idx_q <= idx_d;  hit_idx_q <= hit_idx_d;  free_idx_q <= free_idx_d;  hit_q <= hit_d;
         free_found_q <= free_found_d;  succ_q <= succ_d;  value_q <= value_d;  ready_q <= ready_d;
         count_q <= count_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         CTRL_ST_IDLE: state_d = (bus.operation_in != NOOP) ? CTRL_ST_SCAN : CTRL_ST_IDLE;
         CTRL_ST_SCAN: state_d = (match || last) ? CTRL_ST_DONE : CTRL_ST_SCAN;
         CTRL_ST_DONE: state_d = CTRL_ST_IDLE;
         default:      state_d = CTRL_ST_IDLE;
      endcase
   end

   // Command latch, scan bookkeeping, result capture and store update
   always_comb begin
      op_d = op_q;  key_d = key_q;  val_d = val_q;  idx_d = idx_q;
      hit_d = hit_q;  hit_idx_d = hit_idx_q;  free_found_d = free_found_q;  free_idx_d = free_idx_q;
      succ_d = succ_q;  value_d = value_q;  count_d = count_q;
      wr_en = 1'b0;  wr_set = 1'b0;  wr_clr = 1'b0;  wr_idx = hit_idx_q;
      ready_d = (state_d == CTRL_ST_DONE);
      case (state_q)
         CTRL_ST_IDLE: begin
            idx_d = '0;
            if (bus.operation_in != NOOP) begin
               op_d = bus.operation_in;  key_d = bus.key_in;  val_d = bus.value_in;
               hit_d = 1'b0;  free_found_d = 1'b0;
            end else begin
               op_d = op_q;
            end
         end
         CTRL_ST_SCAN: begin
            if (!rd_valid && !free_found_q) begin
               free_found_d = 1'b1;  free_idx_d = idx_q;
            end else begin
               free_found_d = free_found_q;
            end
            // Results are captured on entry to DONE so they are valid alongside ready_out
            if (match) begin
               hit_d = 1'b1;  hit_idx_d = idx_q;  succ_d = 1'b1;
               value_d = (op_q == GET) ? rd_value : '0;
            end else if (last) begin
               hit_d = 1'b0;  value_d = '0;
               succ_d = (op_q == PUT) && (free_found_q || !rd_valid);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         CTRL_ST_DONE: begin
            if (hit_q) begin
               case (op_q)
                  PUT:     begin wr_en = 1'b1; wr_set = 1'b1; end
                  DELETE:  begin
                     wr_clr = 1'b1;
                     if (count_q != '0) count_d = count_q - 1'b1;
                     else               count_d = count_q;
                  end
                  default: wr_en = 1'b0;
               endcase
            end else if ((op_q == PUT) && free_found_q) begin
               wr_en = 1'b1;  wr_set = 1'b1;  wr_idx = free_idx_q;
               if (count_q != CNT_W'(NUM_ENTRIES)) count_d = count_q + 1'b1;
               else                                count_d = count_q;
            end else begin
               wr_en = 1'b0;
            end
         end
         default: idx_d = '0;
      endcase
   end

   assign bus.ready_out   = ready_q;
   assign bus.op_succ_out = succ_q;
   assign bus.value_out   = value_q;
   assign count_out       = count_q;

`ifdef KV_CACHE_CTRL_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   // Saturating hit/miss counters, bumped once per completed command
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == CTRL_ST_DONE) begin
         if (hit_q) hit_cnt_d  = sat_inc16(hit_cnt_q);
         else       miss_cnt_d = sat_inc16(miss_cnt_q);
      end else begin
         hit_cnt_d = hit_cnt_q;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= 16'd0;
         miss_cnt_q <= 16'd0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count_out  = hit_cnt_q;
   assign miss_count_out = miss_cnt_q;
`else
   assign hit_count_out  = 16'd0;
   assign miss_count_out = 16'd0;
`endif
endmodule
